// File: rtl/ocm_stream_reader_if.sv
// rtl/ocm_stream_reader_if.sv - memory read bus and output stream bundle
interface ocm_stream_reader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output address, chipselect, write, byteenable,
    input  readdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  address, chipselect, write, byteenable,
    output readdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/ocm_stream_reader.sv
// rtl/ocm_stream_reader.sv - burst reader from on-chip memory into a buffered stream
module ocm_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int MEM_DEPTH  = 8960,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  ocm_stream_reader_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]     ptr;
  logic [ADDR_W-1:0]     remain;
  logic                  inflight;
  logic                  inflight_last;

  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic issue;
  logic push;
  logic pop;
  logic nonempty;
  logic last_issue;

  // A read is only issued when its word is guaranteed a FIFO slot on return.
  assign issue      = (state == S_ISSUE) &&
                      (((CW+1)'(count) + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH));
  assign last_issue = issue && (remain == ADDR_W'(1));
  assign push       = inflight;
  assign nonempty   = (count != '0);
  assign pop        = nonempty && bus.out_ready;

  assign bus.chipselect = issue;
  assign bus.address    = ptr;
  assign bus.write      = 1'b0;
  assign bus.byteenable = '1;
  assign bus.out_valid  = nonempty;
  assign bus.out_data   = nonempty ? fifo_data[rd_ptr] : '0;
  assign bus.out_last   = nonempty && fifo_last[rd_ptr];

  assign busy = (state == S_ISSUE) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: issue all reads, then wait for the last word to leave.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_words == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && fifo_last[rd_ptr]) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read pointer, remaining count and in-flight tracking; reset drops returning data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      remain        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if (state == S_IDLE && start) begin
        ptr    <= base_addr;
        remain <= num_words;
      end else if (issue) begin
        ptr    <= (ptr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
        remain <= remain - ADDR_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.readdata;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

  // FIFO pointers and occupancy, allowing push and pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ocm_stream_reader.sv
// tb/tb_ocm_stream_reader.sv - directed self-checking bench for ocm_stream_reader
module tb_ocm_stream_reader;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_words;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] cs_q [$];
  logic [DATA_W-1:0] dat_q [$];
  logic              last_q [$];

  ocm_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ocm_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(8960), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {16'hBEEF, 2'b00, a, 18'd0, a};
  endfunction

  // Memory with one-cycle read latency; junk when not selected.
  always @(posedge clk) begin
    bus.readdata <= bus.chipselect ? mem_word(bus.address) : 64'hDEAD_DEAD_DEAD_DEAD;
  end

  // Record issued reads and accepted stream words.
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.chipselect) cs_q.push_back(bus.address);
      if (bus.out_valid && bus.out_ready) begin
        dat_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    cs_q.delete();
    dat_q.delete();
    last_q.delete();
  endtask

  task automatic go(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    base_addr = b;
    num_words = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
    step();
  endtask

  task automatic check_burst(input string tag, input logic [ADDR_W-1:0] b, input int n);
    logic [ADDR_W-1:0] a;
    check({tag, "_cs_count"}, 64'(cs_q.size()), 64'(n));
    check({tag, "_word_count"}, 64'(dat_q.size()), 64'(n));
    a = b;
    for (int i = 0; i < n; i++) begin
      if (i < cs_q.size()) check({tag, "_addr"}, 64'(cs_q[i]), 64'(a));
      if (i < dat_q.size()) begin
        check({tag, "_data"}, dat_q[i], mem_word(a));
        check({tag, "_last"}, {63'd0, last_q[i]}, {63'd0, (i == n - 1)});
      end
      a = (a == ADDR_W'(8959)) ? '0 : a + ADDR_W'(1);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_chipselect", {63'd0, bus.chipselect}, 64'd0);
    check("rst_out_valid",  {63'd0, bus.out_valid},  64'd0);
    check("rst_out_last",   {63'd0, bus.out_last},   64'd0);
    check("rst_busy",       {63'd0, busy},           64'd0);
    check("rst_done",       {63'd0, done},           64'd0);
    check("rst_address",    64'(bus.address),        64'd0);
    check("rst_out_data",   bus.out_data,            64'd0);
    check("tie_write",      {63'd0, bus.write},      64'd0);
    check("tie_byteenable", 64'(bus.byteenable),     64'hFF);
    reset = 1'b0;
    step();

    // Basic burst, cycle by cycle: base 0x010, 5 words.
    clear_q();
    go(14'h010, 14'd5);
    for (int c = 1; c <= 9; c++) begin
      check("basic_cs",    {63'd0, bus.chipselect}, {63'd0, (c >= 1 && c <= 5)});
      if (c <= 5) check("basic_addr", 64'(bus.address), 64'(14'h010 + c - 1));
      check("basic_valid", {63'd0, bus.out_valid}, {63'd0, (c >= 3 && c <= 7)});
      if (c >= 3 && c <= 7) begin
        check("basic_data", bus.out_data, mem_word(14'(14'h010 + c - 3)));
        check("basic_last", {63'd0, bus.out_last}, {63'd0, (c == 7)});
      end
      check("basic_busy", {63'd0, busy}, {63'd0, (c >= 1 && c <= 7)});
      check("basic_done", {63'd0, done}, {63'd0, (c == 8)});
      step();
    end
    check_burst("basic", 14'h010, 5);

    // Address wrap at the end of memory.
    clear_q();
    go(14'd8958, 14'd4);
    wait_done(40);
    check_burst("wrap", 14'd8958, 4);

    // Backpressure: FIFO fills, reads stop at 4, head is held.
    clear_q();
    bus.out_ready = 1'b0;
    go(14'h100, 14'd10);
    repeat (19) step();
    check("bp_cs_count",  64'(cs_q.size()),        64'd4);
    check("bp_no_words",  64'(dat_q.size()),       64'd0);
    check("bp_valid",     {63'd0, bus.out_valid},  64'd1);
    check("bp_data_held", bus.out_data,            mem_word(14'h100));
    check("bp_last_held", {63'd0, bus.out_last},   64'd0);
    check("bp_busy",      {63'd0, busy},           64'd1);
    bus.out_ready = 1'b1;
    wait_done(80);
    check_burst("bp", 14'h100, 10);

    // Zero-length burst: no reads, done straight away, never busy.
    clear_q();
    go(14'h055, 14'd0);
    check("zero_done1", {63'd0, done},           64'd1);
    check("zero_busy1", {63'd0, busy},           64'd0);
    check("zero_cs",    {63'd0, bus.chipselect}, 64'd0);
    step();
    check("zero_done2", {63'd0, done},           64'd0);
    check("zero_busy2", {63'd0, busy},           64'd0);
    check("zero_reads", 64'(cs_q.size()),        64'd0);

    // Second start mid-burst is ignored.
    clear_q();
    go(14'h200, 14'd6);
    step();
    go(14'h300, 14'd2);
    wait_done(60);
    check_burst("busy_start", 14'h200, 6);

    // Reset with three words buffered, then a clean burst.
    clear_q();
    bus.out_ready = 1'b0;
    go(14'h040, 14'd8);
    repeat (4) step();
    check("mr_prefill_valid", {63'd0, bus.out_valid}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_valid",    {63'd0, bus.out_valid},  64'd0);
    check("mr_busy",     {63'd0, busy},           64'd0);
    check("mr_cs",       {63'd0, bus.chipselect}, 64'd0);
    check("mr_out_data", bus.out_data,            64'd0);
    step();
    check("mr_valid2",   {63'd0, bus.out_valid},  64'd0);
    check("mr_done",     {63'd0, done},           64'd0);
    clear_q();
    bus.out_ready = 1'b1;
    go(14'h020, 14'd3);
    wait_done(40);
    check_burst("post_reset", 14'h020, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ocm_stream_reader.md
OCM_STREAM_READER -- requirements
Module: ocm_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, memory and stream data width.
REQ-003 SHALL have parameter MEM_DEPTH, default 8960, number of memory words; addresses wrap at this value.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of 2, at least 2.
REQ-005 SHALL use one clock and synchronous active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit: one-cycle burst request.
REQ-009 SHALL have port base_addr, input, ADDR_W bits: first word address, sampled with start.
REQ-010 SHALL have port num_words, input, ADDR_W bits: burst length in words, sampled with start.
REQ-011 SHALL have port address, output, ADDR_W bits: memory read address.
REQ-012 SHALL have port chipselect, output, 1 bit: memory read strobe, one word per cycle.
REQ-013 SHALL have port write, output, 1 bit: tied to 0.
REQ-014 SHALL have port byteenable, output, DATA_W/8 bits: tied to all ones.
REQ-015 SHALL have port readdata, input, DATA_W bits: memory data, valid exactly 1 cycle after chipselect.
REQ-016 SHALL have port out_data, output, DATA_W bits: stream data.
REQ-017 SHALL have port out_valid, output, 1 bit: stream data valid.
REQ-018 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-019 SHALL have port out_last, output, 1 bit: marks the final word of the burst.
REQ-020 SHALL have port busy, output, 1 bit: burst in progress.
REQ-021 SHALL have port done, output, 1 bit: one-cycle burst-complete pulse.

Function
REQ-022 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-023 SHALL, in IDLE, accept start and go to ISSUE (num_words>0) or DONE (num_words=0); no memory read occurs when num_words=0.
REQ-024 SHALL ignore start outside IDLE.
REQ-025 SHALL, in ISSUE, assert chipselect with address=current pointer only when fifo_count + inflight < FIFO_DEPTH.
- inflight: reads issued and not yet returned, 0 or 1.
REQ-026 SHALL advance the pointer by 1 per issued read; the value after MEM_DEPTH-1 SHALL be 0.
REQ-027 SHALL go to DRAIN in the cycle after the last read is issued.
REQ-028 SHALL write readdata into the FIFO exactly 1 cycle after each chipselect cycle.
REQ-029 SHALL never drop or reorder words; FIFO overflow is impossible under REQ-025.
REQ-030 SHALL drive out_valid=1 whenever the FIFO is non-empty, with out_data = FIFO head.
REQ-031 SHALL pop the FIFO on out_valid & out_ready.
REQ-032 SHALL support a simultaneous FIFO push and pop in one cycle, with count unchanged.
REQ-033 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-034 SHALL assert out_last together with the num_words-th word only.
REQ-035 SHALL go from DRAIN to DONE in the cycle after the last-word handshake.
REQ-036 SHALL assert done for exactly 1 cycle in DONE, then return to IDLE.
REQ-037 SHALL drive busy=1 in ISSUE and DRAIN, and 0 in IDLE and DONE.
REQ-038 SHALL, with out_ready held at 1, give a first out_valid 3 cycles after the start cycle, followed by 1 word per cycle.

Reset
REQ-039 SHALL, on reset, set the state to IDLE and empty the FIFO.
REQ-040 SHALL, on reset, clear inflight and drive chipselect, out_valid, out_last, busy and done to 0, with address=0 and out_data=0.
REQ-041 SHALL, when reset occurs mid-burst, discard any readdata returning in the following cycle and leave the FIFO empty.

Verification
REQ-042 SHALL cover a basic burst: start with base=0x010, num=5, out_ready=1 -> addresses 0x010..0x014 on 5 consecutive cycles; 5 words in order, out_last on word 5; done 1 cycle after that.
REQ-043 SHALL cover wrap: base=8958, num=4 -> addresses 8958, 8959, 0, 1.
REQ-044 SHALL cover backpressure: num=10 with out_ready=0 for 20 cycles -> exactly 4 chipselects and out_data held; then release -> all 10 words in order with no loss.
REQ-045 SHALL cover a zero-length burst: num=0 -> no chipselect, done 1 cycle after start, busy never 1.
REQ-046 SHALL cover start while busy: a second start mid-burst -> ignored, and the burst length and addresses are unchanged.
REQ-047 SHALL cover mid-burst reset: reset while the FIFO holds 3 words -> next cycle out_valid=0 and state IDLE; a new burst then runs cleanly.
